// File: rtl/snoc_axil_mem_responder_pkg.sv
// Shared SNOC AXI-Lite types, widths, response codes and FSM state types.
package snoc_axil_mem_responder_pkg;

    localparam int unsigned SNOC_ADDRW = 32;
    localparam int unsigned SNOC_DATAW = 64;
    localparam int unsigned SNOC_STRBW = SNOC_DATAW / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [SNOC_ADDRW-1:0] addr;
        logic [2:0]            prot;
    } snoc_axil_ax_s;

    typedef struct packed {
        logic [SNOC_DATAW-1:0] data;
        logic [SNOC_STRBW-1:0] strb;
    } snoc_axil_w_s;

    typedef struct packed {
        logic [1:0] resp;
    } snoc_axil_b_s;

    typedef struct packed {
        logic [SNOC_DATAW-1:0] data;
        logic [1:0]            resp;
    } snoc_axil_r_s;

    typedef struct packed {
        snoc_axil_ax_s aw;
        logic          aw_valid;
        snoc_axil_w_s  w;
        logic          w_valid;
        logic          b_ready;
        snoc_axil_ax_s ar;
        logic          ar_valid;
        logic          r_ready;
    } snoc_axil_req_s;

    typedef struct packed {
        logic         aw_ready;
        logic         w_ready;
        snoc_axil_b_s b;
        logic         b_valid;
        logic         ar_ready;
        snoc_axil_r_s r;
        logic         r_valid;
    } snoc_axil_resp_s;

    typedef enum logic {W_COLLECT, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_RESP} r_state_e;

    // True when every address bit above the word index is zero.
    function automatic logic addr_in_range(input logic [SNOC_ADDRW-1:0] addr,
                                           input int unsigned idx_w);
        return (addr >> (3 + idx_w)) == '0;
    endfunction

endpackage

// File: rtl/snoc_axil_mem_responder_mem.sv
// Word memory with per-byte write enables and a registered read port.
module axil_strb_mem
    import snoc_axil_mem_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    localparam int unsigned IDXW = $clog2(MEM_WORDS)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDXW-1:0]       waddr,
    input  logic [SNOC_DATAW-1:0] wdata,
    input  logic [SNOC_STRBW-1:0] wstrb,
    input  logic                  re,
    input  logic                  rclr,
    input  logic [IDXW-1:0]       raddr,
    output logic [SNOC_DATAW-1:0] rdata
);

    logic [SNOC_DATAW-1:0] mem [MEM_WORDS];

    // Byte-lane write; no reset on the array itself.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned k = 0; k < SNOC_STRBW; k++) begin
                if (wstrb[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    // Registered read; a same-edge write is not visible (old data returned).
    always_ff @(posedge clk) begin
        if (rclr)    rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/snoc_axil_mem_responder.sv
// AXI-Lite responder backed by a strobed word memory; independent write/read paths.
module snoc_axil_mem_responder
    import snoc_axil_mem_responder_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter bit          INIT_ZERO = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  snoc_axil_req_s  axil_req_i,
    output snoc_axil_resp_s axil_resp_o,
    output logic            init_done_o
);

    localparam int unsigned IDXW = $clog2(MEM_WORDS);

    w_state_e w_state, w_state_n;
    r_state_e r_state, r_state_n;

    logic aw_held, aw_held_n, w_held, w_held_n;
    logic [SNOC_ADDRW-1:0] aw_addr_q;
    logic [SNOC_DATAW-1:0] w_data_q;
    logic [SNOC_STRBW-1:0] w_strb_q;

    logic aw_ready_q, aw_ready_n, w_ready_q, w_ready_n;
    logic b_valid_q, b_valid_n, ar_ready_q, ar_ready_n, r_valid_q, r_valid_n;
    logic [1:0] b_resp_q, b_resp_n, r_resp_q, r_resp_n;

    logic [IDXW-1:0] init_cnt;
    logic init_done, init_last, init_done_n;

    logic aw_hs, w_hs, ar_hs, commit, wr_ok, rd_ok, rd_en, rd_clr;
    logic [SNOC_ADDRW-1:0] wr_addr;
    logic [SNOC_DATAW-1:0] wr_data;
    logic [SNOC_STRBW-1:0] wr_strb;

    logic                  mem_we;
    logic [IDXW-1:0]       mem_waddr;
    logic [SNOC_DATAW-1:0] mem_wdata, mem_rdata;
    logic [SNOC_STRBW-1:0] mem_wstrb;

    logic unused_req_bits;
    assign unused_req_bits = ^{axil_req_i.aw.prot, axil_req_i.ar.prot};

    assign init_last   = !init_done && (init_cnt == IDXW'(MEM_WORDS - 1));
    assign init_done_n = init_done || init_last;

    assign aw_hs   = axil_req_i.aw_valid && aw_ready_q;
    assign w_hs    = axil_req_i.w_valid && w_ready_q;
    assign ar_hs   = axil_req_i.ar_valid && ar_ready_q;
    assign wr_addr = aw_held ? aw_addr_q : axil_req_i.aw.addr;
    assign wr_data = w_held ? w_data_q : axil_req_i.w.data;
    assign wr_strb = w_held ? w_strb_q : axil_req_i.w.strb;
    assign wr_ok   = addr_in_range(wr_addr, IDXW);
    assign rd_ok   = addr_in_range(axil_req_i.ar.addr, IDXW);

    // Write FSM next state and next registered outputs; the commit happens on
    // the edge where the second of AW/W is captured, so payload comes via mux.
    always_comb begin
        w_state_n  = w_state;
        aw_held_n  = aw_held;
        w_held_n   = w_held;
        aw_ready_n = 1'b0;
        w_ready_n  = 1'b0;
        b_valid_n  = b_valid_q;
        b_resp_n   = b_resp_q;
        commit     = 1'b0;
        case (w_state)
            W_COLLECT: begin
                aw_held_n = aw_held || aw_hs;
                w_held_n  = w_held || w_hs;
                if (aw_held_n && w_held_n) begin
                    commit    = 1'b1;
                    b_valid_n = 1'b1;
                    b_resp_n  = wr_ok ? RESP_OKAY : RESP_DECERR;
                    w_state_n = W_RESP;
                end else begin
                    aw_ready_n = !aw_held_n && init_done_n;
                    w_ready_n  = !w_held_n && init_done_n;
                end
            end
            W_RESP: begin
                if (b_valid_q && axil_req_i.b_ready) begin
                    aw_held_n  = 1'b0;
                    w_held_n   = 1'b0;
                    b_valid_n  = 1'b0;
                    aw_ready_n = 1'b1;
                    w_ready_n  = 1'b1;
                    w_state_n  = W_COLLECT;
                end
            end
            default: w_state_n = W_COLLECT;
        endcase
    end

    // Read FSM next state; out-of-range reads clear the memory read register.
    always_comb begin
        r_state_n  = r_state;
        ar_ready_n = 1'b0;
        r_valid_n  = r_valid_q;
        r_resp_n   = r_resp_q;
        rd_en      = 1'b0;
        rd_clr     = rst;
        case (r_state)
            R_IDLE: begin
                if (ar_hs) begin
                    rd_en     = rd_ok;
                    rd_clr    = rst || !rd_ok;
                    r_valid_n = 1'b1;
                    r_resp_n  = rd_ok ? RESP_OKAY : RESP_DECERR;
                    r_state_n = R_RESP;
                end else begin
                    ar_ready_n = init_done_n;
                end
            end
            R_RESP: begin
                if (r_valid_q && axil_req_i.r_ready) begin
                    r_valid_n  = 1'b0;
                    ar_ready_n = 1'b1;
                    r_state_n  = R_IDLE;
                end
            end
            default: r_state_n = R_IDLE;
        endcase
    end

    // Memory write port: clear sweep during init, otherwise committed writes.
    always_comb begin
        mem_we    = !rst && commit && wr_ok;
        mem_waddr = wr_addr[3 +: IDXW];
        mem_wdata = wr_data;
        mem_wstrb = wr_strb;
        if (!init_done) begin
            mem_we    = !rst;
            mem_waddr = init_cnt;
            mem_wdata = '0;
            mem_wstrb = '1;
        end
    end

    // State, holding flags, registered outputs and init sweep counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state    <= W_COLLECT;
            r_state    <= R_IDLE;
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_resp_q   <= RESP_OKAY;
            init_cnt   <= '0;
            init_done  <= !INIT_ZERO;
        end else begin
            w_state    <= w_state_n;
            r_state    <= r_state_n;
            aw_held    <= aw_held_n;
            w_held     <= w_held_n;
            aw_ready_q <= aw_ready_n;
            w_ready_q  <= w_ready_n;
            b_valid_q  <= b_valid_n;
            b_resp_q   <= b_resp_n;
            ar_ready_q <= ar_ready_n;
            r_valid_q  <= r_valid_n;
            r_resp_q   <= r_resp_n;
            if (!init_done) init_cnt <= init_cnt + IDXW'(1);
            init_done  <= init_done_n;
        end
    end

    // AW/W payload capture on handshake.
    always_ff @(posedge clk) begin
        if (aw_hs) aw_addr_q <= axil_req_i.aw.addr;
        if (w_hs) begin
            w_data_q <= axil_req_i.w.data;
            w_strb_q <= axil_req_i.w.strb;
        end
    end

    axil_strb_mem #(.MEM_WORDS(MEM_WORDS)) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .wstrb (mem_wstrb),
        .re    (rd_en),
        .rclr  (rd_clr),
        .raddr (axil_req_i.ar.addr[3 +: IDXW]),
        .rdata (mem_rdata)
    );

    assign axil_resp_o.aw_ready = aw_ready_q;
    assign axil_resp_o.w_ready  = w_ready_q;
    assign axil_resp_o.b.resp   = b_resp_q;
    assign axil_resp_o.b_valid  = b_valid_q;
    assign axil_resp_o.ar_ready = ar_ready_q;
    assign axil_resp_o.r.data   = mem_rdata;
    assign axil_resp_o.r.resp   = r_resp_q;
    assign axil_resp_o.r_valid  = r_valid_q;
    assign init_done_o          = init_done;

endmodule

// File: tb/tb_snoc_axil_mem_responder.sv
// Directed bench with a transaction-level memory model checked every cycle.
module tb_snoc_axil_mem_responder;
    import snoc_axil_mem_responder_pkg::*;

    localparam int unsigned MW = 1024;

    logic            clk = 1'b0;
    logic            rst;
    snoc_axil_req_s  req;
    snoc_axil_resp_s resp;
    logic            init_done;

    int tests = 0;
    int fails = 0;

    snoc_axil_mem_responder #(.MEM_WORDS(MW), .INIT_ZERO(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .axil_req_i  (req),
        .axil_resp_o (resp),
        .init_done_o (init_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [63:0] mdl_mem [MW];
    logic [63:0] rq_data [$];
    logic [1:0]  rq_resp [$];
    logic [1:0]  bq [$];
    bit          armed = 0;
    bit          exp_r = 0, exp_b = 0, exp_quiet = 0;
    bit          aw_p = 0, w_p = 0;
    logic [31:0] aw_a;
    logic [63:0] w_d;
    logic [7:0]  w_s;

    function automatic bit in_range(input logic [31:0] addr);
        return addr < 32'(MW * 8);
    endfunction

    // Negedge: check present outputs, then apply the handshakes of the next edge.
    always @(negedge clk) begin
        if (armed) begin
            if (exp_quiet) begin
                chk("reset_quiet", 64'({resp.aw_ready, resp.w_ready, resp.ar_ready,
                                        resp.b_valid, resp.r_valid}), 64'd0);
                exp_quiet = 0;
            end
            if (!init_done)
                chk("init_readies", 64'({resp.aw_ready, resp.w_ready, resp.ar_ready}), 64'd0);
            if (resp.b_valid)
                chk("b_pending_readies", 64'({resp.aw_ready, resp.w_ready}), 64'd0);
            if (exp_r) begin chk("r_latency", 64'(resp.r_valid), 64'd1); exp_r = 0; end
            if (exp_b) begin chk("b_latency", 64'(resp.b_valid), 64'd1); exp_b = 0; end
            if (resp.r_valid) begin
                if (rq_data.size() == 0) chk("r_unexpected", 64'd1, 64'd0);
                else begin
                    chk("r_data", resp.r.data, rq_data[0]);
                    chk("r_resp", 64'(resp.r.resp), 64'(rq_resp[0]));
                    if (req.r_ready) begin void'(rq_data.pop_front()); void'(rq_resp.pop_front()); end
                end
            end
            if (resp.b_valid) begin
                if (bq.size() == 0) chk("b_unexpected", 64'd1, 64'd0);
                else begin
                    chk("b_resp", 64'(resp.b.resp), 64'(bq[0]));
                    if (req.b_ready) void'(bq.pop_front());
                end
            end
            if (rst) begin
                rq_data.delete(); rq_resp.delete(); bq.delete();
                aw_p = 0; w_p = 0; exp_r = 0; exp_b = 0; exp_quiet = 1;
                foreach (mdl_mem[i]) mdl_mem[i] = '0;
            end else begin
                if (req.ar_valid && resp.ar_ready) begin
                    if (in_range(req.ar.addr)) begin
                        rq_data.push_back(mdl_mem[req.ar.addr / 8]);
                        rq_resp.push_back(2'b00);
                    end else begin
                        rq_data.push_back(64'd0);
                        rq_resp.push_back(2'b11);
                    end
                    exp_r = 1;
                end
                if (req.aw_valid && resp.aw_ready) begin aw_p = 1; aw_a = req.aw.addr; end
                if (req.w_valid && resp.w_ready) begin w_p = 1; w_d = req.w.data; w_s = req.w.strb; end
                if (aw_p && w_p) begin
                    if (in_range(aw_a)) begin
                        for (int k = 0; k < 8; k++)
                            if (w_s[k]) mdl_mem[aw_a / 8][8*k +: 8] = w_d[8*k +: 8];
                        bq.push_back(2'b00);
                    end else bq.push_back(2'b11);
                    exp_b = 1; aw_p = 0; w_p = 0;
                end
            end
        end
    end

    // ---------------- stimulus tasks (drive #1 after posedge) ----------------
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send_aw(input logic [31:0] addr);
        bit done = 0;
        req.aw.addr = addr; req.aw_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk); done = resp.aw_ready; step();
        end
        if (!done) chk("aw_timeout", 64'd0, 64'd1);
        req.aw_valid = 1'b0;
    endtask

    task automatic send_w(input logic [63:0] data, input logic [7:0] strb);
        bit done = 0;
        req.w.data = data; req.w.strb = strb; req.w_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk); done = resp.w_ready; step();
        end
        if (!done) chk("w_timeout", 64'd0, 64'd1);
        req.w_valid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] addr);
        bit done = 0;
        req.ar.addr = addr; req.ar_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk); done = resp.ar_ready; step();
        end
        if (!done) chk("ar_timeout", 64'd0, 64'd1);
        req.ar_valid = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] r);
        bit done = 0;
        r = 2'bxx;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (resp.b_valid && req.b_ready) begin done = 1; r = resp.b.resp; end
            step();
        end
        if (!done) chk("b_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_r(output logic [63:0] d, output logic [1:0] r);
        bit done = 0;
        d = 'x; r = 2'bxx;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (resp.r_valid && req.r_ready) begin done = 1; d = resp.r.data; r = resp.r.resp; end
            step();
        end
        if (!done) chk("r_timeout", 64'd0, 64'd1);
    endtask

    task automatic write(input logic [31:0] addr, input logic [63:0] data,
                         input logic [7:0] strb, output logic [1:0] r);
        fork
            send_aw(addr);
            send_w(data, strb);
        join
        wait_b(r);
    endtask

    task automatic read(input logic [31:0] addr, output logic [63:0] d, output logic [1:0] r);
        send_ar(addr);
        wait_r(d, r);
    endtask

    task automatic wait_ready_after_reset(output int cnt);
        cnt = 0;
        while (!resp.ar_ready && cnt < 3000) begin step(); cnt++; end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        logic [1:0]  r, rb;
        int          cnt;

        req = '0; req.b_ready = 1'b1; req.r_ready = 1'b1;
        rst = 1'b1;
        repeat (3) step();
        armed = 1;
        chk("reset_b_valid", 64'(resp.b_valid), 64'd0);
        chk("reset_r_valid", 64'(resp.r_valid), 64'd0);
        chk("reset_readies", 64'({resp.aw_ready, resp.w_ready, resp.ar_ready}), 64'd0);
        chk("reset_r_data", resp.r.data, 64'd0);
        chk("reset_resps", 64'({resp.b.resp, resp.r.resp}), 64'd0);
        chk("reset_init_done", 64'(init_done), 64'd0);

        // Init sweep timing and cleared contents.
        rst = 1'b0;
        wait_ready_after_reset(cnt);
        chk("ar_ready_rise_cycles", 64'(cnt), 64'(MW));
        chk("init_done_after_sweep", 64'(init_done), 64'd1);
        read(32'h8, d, r);
        chk("init_read_data", d, 64'd0);
        chk("init_read_resp", 64'(r), 64'd0);

        // W leads AW by three cycles.
        send_w(64'h1122334455667788, 8'hFF);
        repeat (3) step();
        send_aw(32'h10);
        wait_b(rb);
        chk("w_first_bresp", 64'(rb), 64'd0);
        read(32'h10, d, r);
        chk("w_first_rdata", d, 64'h1122334455667788);

        // Partial strobe merge.
        write(32'h20, 64'hAAAA_AAAA_AAAA_AAAA, 8'hFF, rb);
        write(32'h20, 64'h0000_0000_0000_00FF, 8'h01, rb);
        read(32'h20, d, r);
        chk("strb_merge", d, 64'hAAAA_AAAA_AAAA_AAFF);
        write(32'h20, 64'h1234_5678_9ABC_DEF0, 8'h00, rb);
        chk("strb_zero_bresp", 64'(rb), 64'd0);
        read(32'h20, d, r);
        chk("strb_zero_unchanged", d, 64'hAAAA_AAAA_AAAA_AAFF);

        // Out of range: idx bit 13 set.
        write(32'h2000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, rb);
        chk("oor_bresp", 64'(rb), 64'd3);
        read(32'h2000, d, r);
        chk("oor_rresp", 64'(r), 64'd3);
        chk("oor_rdata", d, 64'd0);
        read(32'h0, d, r);
        chk("oor_no_alias_write", d, 64'd0);

        // B backpressure while reads keep flowing.
        req.b_ready = 1'b0;
        fork
            send_aw(32'h40);
            send_w(64'h0F0F_0F0F_0F0F_0F0F, 8'hFF);
        join
        for (int i = 0; i < 5; i++) begin
            read(32'h10, d, r);
            chk("stall_read_data", d, 64'h1122334455667788);
        end
        repeat (5) step();
        chk("stall_readies_low", 64'({resp.aw_ready, resp.w_ready}), 64'd0);
        chk("stall_b_valid", 64'(resp.b_valid), 64'd1);
        req.b_ready = 1'b1;
        wait_b(rb);
        chk("stall_bresp", 64'(rb), 64'd0);
        read(32'h40, d, r);
        chk("stall_write_data", d, 64'h0F0F_0F0F_0F0F_0F0F);

        // Same-edge commit and AR to the same word.
        write(32'h30, 64'h5, 8'hFF, rb);
        send_w(64'h9, 8'hFF);
        fork
            send_aw(32'h30);
            send_ar(32'h30);
        join
        fork
            wait_b(rb);
            wait_r(d, r);
        join
        chk("collision_old_data", d, 64'h5);
        read(32'h30, d, r);
        chk("collision_new_data", d, 64'h9);

        // Reset while B is pending, then memory cleared again.
        req.b_ready = 1'b0;
        fork
            send_aw(32'h48);
            send_w(64'h7777_7777_7777_7777, 8'hFF);
        join
        step();
        chk("pre_reset_b_valid", 64'(resp.b_valid), 64'd1);
        rst = 1'b1;
        step();
        chk("reset_clears_b_valid", 64'(resp.b_valid), 64'd0);
        rst = 1'b0;
        req.b_ready = 1'b1;
        wait_ready_after_reset(cnt);
        chk("reinit_cycles", 64'(cnt), 64'(MW));
        read(32'h10, d, r);
        chk("reinit_cleared_10", d, 64'd0);
        read(32'h48, d, r);
        chk("reinit_cleared_48", d, 64'd0);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
